pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 230 +++++++++++++++++++++++
 tb/tb_pwm_capture.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and duty (percent) of an async PWM input.
// Optional glitch filter is compiled in with `define PWM_CAP_FILTER_EN.
//
// Ports:
//   clk       in   rising-edge system clock
//   reset     in   asynchronous, active-high reset
//   pwm_in    in   asynchronous PWM waveform under measurement
//   enable    in   measurement enable (level); low aborts and idles the block
//   valid     out  one-cycle pulse, period/high_time/duty_pct updated this cycle
//   period    out  last period, rising edge to rising edge, in clk cycles
//   high_time out  last high time, in clk cycles
//   duty_pct  out  floor(high_time*100/period)
//   timeout   out  no edge seen for 2^CNT_W-1 cycles
//   overrun   out  sticky: a completed period was dropped, divider busy
module pwm_capture #(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    input  logic             enable,
    output logic             valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [6:0]       duty_pct,
    output logic             timeout,
    output logic             overrun
);
    localparam int NW = CNT_W + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

    logic sync1_q, sync2_q;
    logic cond, cond_dly_q;
    logic rise, fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_CAP_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    logic          filt_q;
    logic [FW-1:0] fcnt_q;

    // Flip only after FILT_LEN consecutive samples that disagree with the
    // current conditioned level; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else if (sync2_q == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == FW'(FILT_LEN - 1)) begin
            filt_q <= sync2_q;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + FW'(1);
        end
    end

    assign cond = filt_q;
`else
    logic unused_filt_len;
    assign unused_filt_len = |FILT_LEN;
    assign cond = sync2_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cond_dly_q <= 1'b0;
        else       cond_dly_q <= cond;
    end

    assign rise = cond & ~cond_dly_q;
    assign fall = ~cond & cond_dly_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic             capture, to_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_lat_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_lat_q <= hi_lat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_lat_d = hi_lat_q;
        capture  = 1'b0;
        to_hit   = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = WAIT_RISE;
                    cnt_d   = '0;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d  = LOW;
                        hi_lat_d = cnt_q;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end else if (cnt_q == CNT_MAX) begin
                        to_hit  = 1'b1;
                        state_d = WAIT_RISE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_d = HIGH;
                        capture = 1'b1;
                        cnt_d   = CNT_W'(1);
                    end else if (cnt_q == CNT_MAX) begin
                        to_hit  = 1'b1;
                        state_d = WAIT_RISE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic timeout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        timeout_q <= 1'b0;
        else if (!enable) timeout_q <= 1'b0;
        else if (to_hit)  timeout_q <= 1'b1;
        else if (rise)    timeout_q <= 1'b0;
    end

    // Restoring divider: the divisor starts shifted left by 6 and moves
    // right one place per step, yielding quotient bits 6..0 MSB first.
    logic             busy_q;
    logic [2:0]       step_q;
    logic [NW-1:0]    rem_q, dsh_q;
    logic [6:0]       quo_q;
    logic [CNT_W-1:0] per_cap_q, hi_cap_q;
    logic             valid_q, overrun_q;
    logic [CNT_W-1:0] period_q, high_q;
    logic [6:0]       duty_q;
    logic             ge;
    logic [6:0]       quo_nxt;

    assign ge      = (rem_q >= dsh_q);
    assign quo_nxt = {quo_q[5:0], ge};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q    <= 1'b0;
            step_q    <= '0;
            rem_q     <= '0;
            dsh_q     <= '0;
            quo_q     <= '0;
            per_cap_q <= '0;
            hi_cap_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            duty_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            if (!enable) begin
                busy_q    <= 1'b0;
                overrun_q <= 1'b0;
            end else if (busy_q) begin
                if (ge) rem_q <= rem_q - dsh_q;
                dsh_q  <= dsh_q >> 1;
                quo_q  <= quo_nxt;
                step_q <= step_q + 3'd1;
                if (step_q == 3'd6) begin
                    busy_q   <= 1'b0;
                    valid_q  <= 1'b1;
                    period_q <= per_cap_q;
                    high_q   <= hi_cap_q;
                    duty_q   <= quo_nxt;
                end
                if (capture) overrun_q <= 1'b1;
            end else if (capture) begin
                busy_q    <= 1'b1;
                step_q    <= '0;
                rem_q     <= NW'(hi_lat_q) * NW'(100);
                dsh_q     <= {1'b0, cnt_q, 6'b0};
                quo_q     <= '0;
                per_cap_q <= cnt_q;
                hi_cap_q  <= hi_lat_q;
            end
        end
    end

    assign valid     = valid_q;
    assign period    = period_q;
    assign high_time = high_q;
    assign duty_pct  = duty_q;
    assign timeout   = timeout_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: table vectors, directed corner sequences and random
// periods checked against an arithmetic model of the measurement.
module tb_pwm_capture;
    localparam int CW   = 16;
    localparam int FILT = 4;
`ifdef PWM_CAP_FILTER_EN
    localparam int LAT    = 2 + FILT;
    localparam int MINSEG = FILT;
`else
    localparam int LAT    = 2;
    localparam int MINSEG = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pwm_in = 1'b0;
    logic          enable = 1'b0;
    logic          valid;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic [6:0]    duty_pct;
    logic          timeout;
    logic          overrun;

    pwm_capture #(.CNT_W(CW), .FILT_LEN(FILT)) dut (
        .clk(clk), .reset(reset), .pwm_in(pwm_in), .enable(enable),
        .valid(valid), .period(period), .high_time(high_time),
        .duty_pct(duty_pct), .timeout(timeout), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct { int p; int h; int d; int c; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   model_on = 1'b0;
    bit   prev_ok  = 1'b0;
    int   prev_h, prev_l;
    int   nvalid = 0;
    int   vlog_p[$];
    int   vlog_h[$];
    int   vlog_d[$];

    always @(negedge clk) begin
        if (!reset && valid) begin
            nvalid++;
            vlog_p.push_back(int'(period));
            vlog_h.push_back(int'(high_time));
            vlog_d.push_back(int'(duty_pct));
            if (model_on) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("m_period", 64'(period), 64'(mon_e.p));
                    chk("m_high", 64'(high_time), 64'(mon_e.h));
                    chk("m_duty", 64'(duty_pct), 64'(mon_e.d));
                    chk("m_cycle", 64'(cyc), 64'(mon_e.c));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected result of the period that the rise driven now completes.
    task automatic push_exp();
        exp_t e;
        if (prev_ok) begin
            e.p = prev_h + prev_l;
            e.h = prev_h;
            e.d = (prev_h * 100) / (prev_h + prev_l);
            e.c = cyc + LAT + 8;
            exp_q.push_back(e);
        end
    endtask

    task automatic period_seg(input int h, input int l);
        pwm_in = 1'b1;
        if (model_on) push_exp();
        step(h);
        pwm_in = 1'b0;
        step(l);
        prev_ok = 1'b1;
        prev_h  = h;
        prev_l  = l;
    endtask

    task automatic tail(input int h);
        pwm_in = 1'b1;
        if (model_on) push_exp();
        prev_ok = 1'b0;
        step(h);
        pwm_in = 1'b0;
        step(20);
    endtask

    task automatic restart();
        enable = 1'b0;
        pwm_in = 1'b0;
        step(LAT + 4);
        enable = 1'b1;
        step(3);
        prev_ok = 1'b0;
    endtask

    typedef struct { int hi; int lo; int p; int h; int d; int ov; } vec_t;
    vec_t tv[10];

    initial begin
        #(96000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        int nv0;
        tv[0] = '{40, 60, 100, 40, 40, 0};
        tv[1] = '{1, 2, 3, 1, 33, 1};
        tv[2] = '{10, 40, 50, 10, 20, 0};
        tv[3] = '{25, 25, 50, 25, 50, 0};
        tv[4] = '{1, 9, 10, 1, 10, 0};
        tv[5] = '{7, 1, 8, 7, 87, 0};
        tv[6] = '{99, 1, 100, 99, 99, 0};
        tv[7] = '{3, 4, 7, 3, 42, 1};
        tv[8] = '{200, 55, 255, 200, 78, 0};
        tv[9] = '{1, 1, 2, 1, 50, 1};

        #1 reset = 1'b1;
        #1;
        chk("rst_period", 64'(period), 64'd0);
        chk("rst_high", 64'(high_time), 64'd0);
        chk("rst_duty", 64'(duty_pct), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        step(3);
        reset = 1'b0;
        step(2);

        // Basic 100/40 waveform: first valid after the second rise.
        enable = 1'b1;
        step(5);
        model_on = 1'b1;
        nv0 = nvalid;
        vlog_p.delete(); vlog_h.delete(); vlog_d.delete();
        for (int i = 0; i < 3; i++) period_seg(40, 60);
        tail(40);
        chk("basic_nvalid", 64'(nvalid - nv0), 64'd3);
        chk("basic_period", 64'(vlog_p[0]), 64'd100);
        chk("basic_high", 64'(vlog_h[0]), 64'd40);
        chk("basic_duty", 64'(vlog_d[0]), 64'd40);
        model_on = 1'b0;

        // Table vectors: 4 periods plus closing rise, check held results.
        foreach (tv[i]) begin
            if (tv[i].hi < MINSEG || tv[i].lo < MINSEG) continue;
            restart();
            for (int k = 0; k < 4; k++) period_seg(tv[i].hi, tv[i].lo);
            tail(tv[i].hi);
            chk($sformatf("tv%0d_period", i), 64'(period), 64'(tv[i].p));
            chk($sformatf("tv%0d_high", i), 64'(high_time), 64'(tv[i].h));
            chk($sformatf("tv%0d_duty", i), 64'(duty_pct), 64'(tv[i].d));
            chk($sformatf("tv%0d_overrun", i), 64'(overrun), 64'(tv[i].ov));
        end
        enable = 1'b0;
        step(2);
        chk("overrun_clear", 64'(overrun), 64'd0);

        // Reset in the middle of a division.
        restart();
        period_seg(40, 60);
        pwm_in = 1'b1;
        step(LAT + 3);
        reset  = 1'b1;
        pwm_in = 1'b0;
        #1;
        chk("midrst_period", 64'(period), 64'd0);
        chk("midrst_high", 64'(high_time), 64'd0);
        chk("midrst_duty", 64'(duty_pct), 64'd0);
        chk("midrst_valid", 64'(valid), 64'd0);
        step(2);
        reset = 1'b0;
        nv0 = nvalid;
        step(15);
        chk("midrst_novalid", 64'(nvalid - nv0), 64'd0);
        model_on = 1'b1;
        prev_ok  = 1'b0;
        period_seg(40, 60);
        tail(40);
        chk("midrst_resume", 64'(nvalid - nv0), 64'd1);

        // Enable dropped 20 cycles into a period.
        restart();
        pwm_in = 1'b1;
        step(20);
        enable = 1'b0;
        nv0 = nvalid;
        step(30);
        chk("gap_novalid", 64'(nvalid - nv0), 64'd0);
        chk("gap_period", 64'(period), 64'd100);
        chk("gap_high", 64'(high_time), 64'd40);
        chk("gap_duty", 64'(duty_pct), 64'd40);
        enable = 1'b1;
        step(10);
        pwm_in = 1'b0;
        step(30);
        prev_ok = 1'b0;
        period_seg(25, 35);
        tail(25);
        chk("gap_resume", 64'(nvalid - nv0), 64'd1);
        chk("gap_queue", 64'(exp_q.size()), 64'd0);
        model_on = 1'b0;

        // 50-cycle period, high 10 with a 2-cycle low glitch inside.
        restart();
        vlog_p.delete(); vlog_h.delete(); vlog_d.delete();
        for (int k = 0; k < 3; k++) begin
            pwm_in = 1'b1; step(4);
            pwm_in = 1'b0; step(2);
            pwm_in = 1'b1; step(4);
            pwm_in = 1'b0; step(40);
        end
        tail(10);
        chk("glitch_any", 64'(vlog_p.size() != 0), 64'd1);
`ifdef PWM_CAP_FILTER_EN
        chk("glitch_period", 64'(vlog_p[0]), 64'd50);
        chk("glitch_high", 64'(vlog_h[0]), 64'd10);
        chk("glitch_duty", 64'(vlog_d[0]), 64'd20);
`else
        chk("glitch_period", 64'(vlog_p[0]), 64'd6);
        chk("glitch_high", 64'(vlog_h[0]), 64'd4);
        chk("glitch_duty", 64'(vlog_d[0]), 64'd66);
`endif

        // Held high: timeout after 65535 counted cycles, cleared by a rise.
        restart();
        model_on = 1'b1;
        nv0 = nvalid;
        pwm_in = 1'b1;
        step(LAT + 65535);
        chk("to_before", 64'(timeout), 64'd0);
        step(1);
        chk("to_set", 64'(timeout), 64'd1);
        step(100);
        chk("to_novalid", 64'(nvalid - nv0), 64'd0);
        pwm_in = 1'b0;
        step(10);
        pwm_in = 1'b1;
        step(LAT);
        chk("to_held", 64'(timeout), 64'd1);
        step(1);
        chk("to_clear", 64'(timeout), 64'd0);

        // Random periods against the arithmetic model.
        restart();
        for (int k = 0; k < 30; k++)
            period_seg($urandom_range(60, 5), $urandom_range(60, 5));
        tail($urandom_range(60, 5));
        chk("rand_queue", 64'(exp_q.size()), 64'd0);
        chk("rand_overrun", 64'(overrun), 64'd0);
        model_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
